alu_issue_queue: RTL and testbench

- Age-ordered issue queue directly upstream of the ALU.
- Accepts renamed ALU ops from dispatch and tracks operand readiness by physical-register tag.
- Captures operand values from the writeback broadcast.
- Each cycle, presents the oldest fully-ready op to the ALU as op code, two data words and a destination tag.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_iq_src.sv | 41 ++++
 rtl/alu_issue_queue.sv | 176 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue queue.
//   - ALU op-code constants.
//   - Default datapath widths and the derived physical-register tag width PREG_IDX_SIZE.
//   - iq_src_t / iq_entry_t: layout of one source operand and of one queue entry.
//   - src_wakeup: applies a writeback broadcast to a single source operand.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam int unsigned IQ_WORD_SIZE   = 32;
    localparam int unsigned IQ_NUM_P_REGS  = 64;
    localparam int unsigned IQ_ALU_OP_SIZE = 4;
    localparam int unsigned PREG_IDX_SIZE  = $clog2(IQ_NUM_P_REGS);

    typedef struct packed {
        logic [PREG_IDX_SIZE-1:0] tag;
        logic                     rdy;
        logic [IQ_WORD_SIZE-1:0]  data;
    } iq_src_t;

    typedef struct packed {
        logic [IQ_ALU_OP_SIZE-1:0] op;
        iq_src_t                   src0;
        iq_src_t                   src1;
        logic [PREG_IDX_SIZE-1:0]  dst_tag;
    } iq_entry_t;

    // A waiting source whose tag is being broadcast becomes ready with the broadcast value.
    function automatic iq_src_t src_wakeup(input iq_src_t                  src,
                                           input logic                     wb_valid,
                                           input logic [PREG_IDX_SIZE-1:0] wb_tag,
                                           input logic [IQ_WORD_SIZE-1:0]  wb_data);
        iq_src_t res;
        res = src;
        if (!src.rdy && wb_valid && (src.tag == wb_tag)) begin
            res.rdy  = 1'b1;
            res.data = wb_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_iq_src.sv
// alu_iq_src: per-operand wakeup logic for one source of one issue-queue slot (combinational).
//   i_src       stored operand (tag / rdy / data)
//   i_wb_*      writeback broadcast (valid, tag, data)
//   o_src_next  operand value to store at the next edge (woken if the broadcast matches)
//   o_sel_rdy   readiness seen by the select logic this cycle
//   o_sel_data  operand value presented on the issue port this cycle
// Optional macro ALU_IQ_WB_BYPASS_EN: a broadcast hit counts as ready in the same cycle and the
// broadcast value is forwarded to the issue port.
module alu_iq_src
    import alu_pkg::*;
(
    input  iq_src_t                  i_src,
    input  logic                     i_wb_valid,
    input  logic [PREG_IDX_SIZE-1:0] i_wb_tag,
    input  logic [IQ_WORD_SIZE-1:0]  i_wb_data,
    output iq_src_t                  o_src_next,
    output logic                     o_sel_rdy,
    output logic [IQ_WORD_SIZE-1:0]  o_sel_data
);

    logic w_hit;

    assign w_hit = i_wb_valid && !i_src.rdy && (i_src.tag == i_wb_tag);

    always_comb begin
        o_src_next = i_src;
        if (w_hit) begin
            o_src_next.rdy  = 1'b1;
            o_src_next.data = i_wb_data;
        end
    end

`ifdef ALU_IQ_WB_BYPASS_EN
    assign o_sel_rdy  = i_src.rdy || w_hit;
    assign o_sel_data = w_hit ? i_wb_data : i_src.data;
`else
    assign o_sel_rdy  = i_src.rdy;
    assign o_sel_data = i_src.data;
`endif

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: age-ordered collapsing issue queue feeding the ALU.
//   clk_i, rst_i (sync, active high), flush_i      control
//   dispatch_*                                      renamed op from dispatch (valid/ready)
//   wb_valid_i, wb_tag_i, wb_data_i                 writeback broadcast for operand wakeup
//   issue_*                                         oldest fully-ready op to the ALU (valid/ready)
// Slot 0 is the oldest entry; valid entries occupy slots 0..count-1.
// Optional macro ALU_IQ_WB_BYPASS_EN: same-cycle broadcast makes an op issuable immediately.
// The entry layout follows the alu_pkg widths; parameter overrides must match the package.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = IQ_WORD_SIZE,
    parameter int unsigned NUM_P_REGS  = IQ_NUM_P_REGS,
    parameter int unsigned ALU_OP_SIZE = IQ_ALU_OP_SIZE,
    parameter int unsigned IQ_DEPTH    = 8,
    localparam int unsigned PREG_W     = $clog2(NUM_P_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   dispatch_valid_i,
    output logic                   dispatch_ready_o,
    input  logic [ALU_OP_SIZE-1:0] dispatch_alu_op_i,
    input  logic [PREG_W-1:0]      dispatch_src0_tag_i,
    input  logic [PREG_W-1:0]      dispatch_src1_tag_i,
    input  logic                   dispatch_src0_rdy_i,
    input  logic                   dispatch_src1_rdy_i,
    input  logic [WORD_SIZE-1:0]   dispatch_src0_data_i,
    input  logic [WORD_SIZE-1:0]   dispatch_src1_data_i,
    input  logic [PREG_W-1:0]      dispatch_dst_tag_i,
    input  logic                   wb_valid_i,
    input  logic [PREG_W-1:0]      wb_tag_i,
    input  logic [WORD_SIZE-1:0]   wb_data_i,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    output logic [ALU_OP_SIZE-1:0] issue_alu_op_o,
    output logic [WORD_SIZE-1:0]   issue_data0_o,
    output logic [WORD_SIZE-1:0]   issue_data1_o,
    output logic [PREG_W-1:0]      issue_dst_tag_o
);

    localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(IQ_DEPTH);

    iq_entry_t             r_entries [IQ_DEPTH];
    logic [CNT_W-1:0]      r_count;

    iq_src_t               w_src0_next [IQ_DEPTH];
    iq_src_t               w_src1_next [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]   w_rdy0;
    logic [IQ_DEPTH-1:0]   w_rdy1;
    logic [WORD_SIZE-1:0]  w_data0 [IQ_DEPTH];
    logic [WORD_SIZE-1:0]  w_data1 [IQ_DEPTH];

    logic                  w_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_issue;
    logic                  w_dispatch;
    logic [CNT_W-1:0]      w_wr_idx;
    logic [CNT_W-1:0]      w_count_next;
    iq_src_t               w_disp_raw0;
    iq_src_t               w_disp_raw1;
    iq_entry_t             w_disp_entry;
    iq_entry_t             w_woken [IQ_DEPTH];
    iq_entry_t             w_next  [IQ_DEPTH];

    for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_slot
        alu_iq_src u_src0 (
            .i_src      (r_entries[g].src0),
            .i_wb_valid (wb_valid_i),
            .i_wb_tag   (wb_tag_i),
            .i_wb_data  (wb_data_i),
            .o_src_next (w_src0_next[g]),
            .o_sel_rdy  (w_rdy0[g]),
            .o_sel_data (w_data0[g])
        );
        alu_iq_src u_src1 (
            .i_src      (r_entries[g].src1),
            .i_wb_valid (wb_valid_i),
            .i_wb_tag   (wb_tag_i),
            .i_wb_data  (wb_data_i),
            .o_src_next (w_src1_next[g]),
            .o_sel_rdy  (w_rdy1[g]),
            .o_sel_data (w_data1[g])
        );
    end

    assign dispatch_ready_o = (r_count < CNT_W'(IQ_DEPTH)) && !rst_i;
    assign w_dispatch       = dispatch_valid_i && dispatch_ready_o;
    assign w_issue          = w_found && issue_ready_i;

    // Oldest ready wins: scan from the top so the lowest index is written last.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < r_count) && w_rdy0[i] && w_rdy1[i]) begin
                w_found   = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        issue_valid_o   = 1'b0;
        issue_alu_op_o  = '0;
        issue_data0_o   = '0;
        issue_data1_o   = '0;
        issue_dst_tag_o = '0;
        if (w_found) begin
            issue_valid_o   = 1'b1;
            issue_alu_op_o  = r_entries[w_sel_idx].op;
            issue_data0_o   = w_data0[w_sel_idx];
            issue_data1_o   = w_data1[w_sel_idx];
            issue_dst_tag_o = r_entries[w_sel_idx].dst_tag;
        end
    end

    always_comb begin
        w_disp_raw0.tag  = dispatch_src0_tag_i;
        w_disp_raw0.rdy  = dispatch_src0_rdy_i;
        w_disp_raw0.data = dispatch_src0_data_i;
        w_disp_raw1.tag  = dispatch_src1_tag_i;
        w_disp_raw1.rdy  = dispatch_src1_rdy_i;
        w_disp_raw1.data = dispatch_src1_data_i;

        w_disp_entry.op      = dispatch_alu_op_i;
        w_disp_entry.src0    = src_wakeup(w_disp_raw0, wb_valid_i, wb_tag_i, wb_data_i);
        w_disp_entry.src1    = src_wakeup(w_disp_raw1, wb_valid_i, wb_tag_i, wb_data_i);
        w_disp_entry.dst_tag = dispatch_dst_tag_i;

        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_woken[i].op      = r_entries[i].op;
            w_woken[i].src0    = w_src0_next[i];
            w_woken[i].src1    = w_src1_next[i];
            w_woken[i].dst_tag = r_entries[i].dst_tag;
            w_next[i]          = w_woken[i];
        end

        // Collapse over the issued slot, then append behind the surviving entries.
        if (w_issue) begin
            for (int i = 0; i < IQ_DEPTH - 1; i++) begin
                if (IDX_W'(i) >= w_sel_idx) begin
                    w_next[i] = w_woken[i+1];
                end
            end
            w_next[IQ_DEPTH-1] = '0;
        end

        w_wr_idx = w_issue ? (r_count - 1'b1) : r_count;
        if (w_dispatch) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (CNT_W'(i) == w_wr_idx) begin
                    w_next[i] = w_disp_entry;
                end
            end
        end

        w_count_next = r_count + CNT_W'(w_dispatch) - CNT_W'(w_issue);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_count <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_count <= w_count_next;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_entries[i] <= w_next[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue.
// Covers reset, ready-at-dispatch issue, wakeup, dispatch bypass, age ordering, full queue with
// simultaneous dispatch/issue, and flush. Honours ALU_IQ_WB_BYPASS_EN when defined.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        dispatch_valid_i;
    logic        dispatch_ready_o;
    logic [3:0]  dispatch_alu_op_i;
    logic [5:0]  dispatch_src0_tag_i;
    logic [5:0]  dispatch_src1_tag_i;
    logic        dispatch_src0_rdy_i;
    logic        dispatch_src1_rdy_i;
    logic [31:0] dispatch_src0_data_i;
    logic [31:0] dispatch_src1_data_i;
    logic [5:0]  dispatch_dst_tag_i;
    logic        wb_valid_i;
    logic [5:0]  wb_tag_i;
    logic [31:0] wb_data_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [3:0]  issue_alu_op_o;
    logic [31:0] issue_data0_o;
    logic [31:0] issue_data1_o;
    logic [5:0]  issue_dst_tag_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_issue_queue u_dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .flush_i              (flush_i),
        .dispatch_valid_i     (dispatch_valid_i),
        .dispatch_ready_o     (dispatch_ready_o),
        .dispatch_alu_op_i    (dispatch_alu_op_i),
        .dispatch_src0_tag_i  (dispatch_src0_tag_i),
        .dispatch_src1_tag_i  (dispatch_src1_tag_i),
        .dispatch_src0_rdy_i  (dispatch_src0_rdy_i),
        .dispatch_src1_rdy_i  (dispatch_src1_rdy_i),
        .dispatch_src0_data_i (dispatch_src0_data_i),
        .dispatch_src1_data_i (dispatch_src1_data_i),
        .dispatch_dst_tag_i   (dispatch_dst_tag_i),
        .wb_valid_i           (wb_valid_i),
        .wb_tag_i             (wb_tag_i),
        .wb_data_i            (wb_data_i),
        .issue_valid_o        (issue_valid_o),
        .issue_ready_i        (issue_ready_i),
        .issue_alu_op_o       (issue_alu_op_o),
        .issue_data0_o        (issue_data0_o),
        .issue_data1_o        (issue_data1_o),
        .issue_dst_tag_o      (issue_dst_tag_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // When v is 0 the payload must be all zeros.
    task automatic check_issue(input string tag, input logic v, input logic [3:0] op,
                               input int unsigned d0, input int unsigned d1,
                               input int unsigned dst);
        check_eq({tag, "_valid"}, 64'(issue_valid_o), 64'(v));
        check_eq({tag, "_op"}, 64'(issue_alu_op_o), v ? 64'(op) : 64'd0);
        check_eq({tag, "_d0"}, 64'(issue_data0_o), v ? 64'(d0) : 64'd0);
        check_eq({tag, "_d1"}, 64'(issue_data1_o), v ? 64'(d1) : 64'd0);
        check_eq({tag, "_dst"}, 64'(issue_dst_tag_o), v ? 64'(dst) : 64'd0);
    endtask

    task automatic disp(input logic [3:0] op,
                        input int unsigned t0, input logic r0, input int unsigned d0,
                        input int unsigned t1, input logic r1, input int unsigned d1,
                        input int unsigned dst);
        dispatch_valid_i     = 1'b1;
        dispatch_alu_op_i    = op;
        dispatch_src0_tag_i  = 6'(t0);
        dispatch_src0_rdy_i  = r0;
        dispatch_src0_data_i = d0;
        dispatch_src1_tag_i  = 6'(t1);
        dispatch_src1_rdy_i  = r1;
        dispatch_src1_data_i = d1;
        dispatch_dst_tag_i   = 6'(dst);
    endtask

    task automatic no_disp();
        dispatch_valid_i = 1'b0;
    endtask

    task automatic wb(input logic v, input int unsigned tag, input int unsigned data);
        wb_valid_i = v;
        wb_tag_i   = 6'(tag);
        wb_data_i  = data;
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        issue_ready_i = 1'b0;
        wb(1'b0, 0, 0);
        disp(ALU_AND, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        no_disp();

        // Reset
        tick();
        tick();
        check_eq("rst_ready", 64'(dispatch_ready_o), 64'd0);
        check_issue("rst", 1'b0, 4'd0, 0, 0, 0);
        rst_i = 1'b0;
        settle();
        check_eq("idle_ready", 64'(dispatch_ready_o), 64'd1);
        check_issue("idle", 1'b0, 4'd0, 0, 0, 0);

        // Ready at dispatch: issuable one cycle later
        issue_ready_i = 1'b1;
        disp(ALU_ADD, 1, 1'b1, 5, 2, 1'b1, 7, 10);
        settle();
        check_issue("add_pre", 1'b0, 4'd0, 0, 0, 0);
        tick();
        no_disp();
        settle();
        check_issue("add", 1'b1, ALU_ADD, 5, 7, 10);
        tick();
        settle();
        check_issue("add_gone", 1'b0, 4'd0, 0, 0, 0);

        // Wakeup of a waiting source
        disp(ALU_SUB, 12, 1'b0, 0, 13, 1'b1, 1, 11);
        tick();
        no_disp();
        settle();
        check_issue("sub_wait", 1'b0, 4'd0, 0, 0, 0);
        wb(1'b1, 12, 32'h20);
        settle();
`ifdef ALU_IQ_WB_BYPASS_EN
        check_issue("sub_byp", 1'b1, ALU_SUB, 32'h20, 1, 11);
        tick();
        wb(1'b0, 0, 0);
        settle();
        check_issue("sub_gone", 1'b0, 4'd0, 0, 0, 0);
`else
        check_issue("sub_wbcyc", 1'b0, 4'd0, 0, 0, 0);
        tick();
        wb(1'b0, 0, 0);
        settle();
        check_issue("sub_woken", 1'b1, ALU_SUB, 32'h20, 1, 11);
        tick();
        settle();
        check_issue("sub_gone", 1'b0, 4'd0, 0, 0, 0);
`endif

        // Dispatch-time bypass from the broadcast
        wb(1'b1, 5, 32'h55);
        disp(ALU_ADD, 5, 1'b0, 0, 6, 1'b1, 3, 12);
        tick();
        wb(1'b0, 0, 0);
        no_disp();
        settle();
        check_issue("dbyp", 1'b1, ALU_ADD, 32'h55, 3, 12);
        tick();
        settle();
        check_issue("dbyp_gone", 1'b0, 4'd0, 0, 0, 0);

        // Age ordering: A waits on tag 3, B and C ready
        issue_ready_i = 1'b0;
        disp(ALU_AND, 3, 1'b0, 0, 4, 1'b1, 4, 20);
        tick();
        disp(ALU_XOR, 1, 1'b1, 1, 2, 1'b1, 2, 21);
        tick();
        disp(ALU_SRA, 1, 1'b1, 8, 2, 1'b1, 1, 22);
        tick();
        no_disp();
        settle();
        check_issue("age_b", 1'b1, ALU_XOR, 1, 2, 21);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        settle();
        check_issue("age_c", 1'b1, ALU_SRA, 8, 1, 22);
        wb(1'b1, 3, 32'h33);
        disp(ALU_ADD, 1, 1'b1, 9, 2, 1'b1, 9, 23);
        tick();
        wb(1'b0, 0, 0);
        no_disp();
        settle();
        check_issue("age_a", 1'b1, ALU_AND, 32'h33, 4, 20);
        issue_ready_i = 1'b1;
        tick();
        check_issue("age_c2", 1'b1, ALU_SRA, 8, 1, 22);
        tick();
        check_issue("age_d", 1'b1, ALU_ADD, 9, 9, 23);
        tick();
        check_issue("age_empty", 1'b0, 4'd0, 0, 0, 0);

        // Fill the queue, then dispatch and issue in the same cycle
        issue_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(ALU_ADD, 1, 1'b1, i, 2, 1'b1, 0, 30 + i);
            tick();
        end
        no_disp();
        settle();
        check_eq("full_ready", 64'(dispatch_ready_o), 64'd0);
        check_issue("full_head", 1'b1, ALU_ADD, 0, 0, 30);
        issue_ready_i = 1'b1;
        tick();
        check_eq("one_out_ready", 64'(dispatch_ready_o), 64'd1);
        check_issue("one_out_head", 1'b1, ALU_ADD, 1, 0, 31);
        disp(ALU_ADD, 1, 1'b1, 8, 2, 1'b1, 0, 38);
        tick();
        issue_ready_i = 1'b0;
        disp(ALU_ADD, 1, 1'b1, 9, 2, 1'b1, 0, 39);
        settle();
        check_eq("simul_ready", 64'(dispatch_ready_o), 64'd1);
        tick();
        no_disp();
        settle();
        check_eq("refull_ready", 64'(dispatch_ready_o), 64'd0);
        issue_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_issue($sformatf("drain%0d", k), 1'b1, ALU_ADD, 2 + k, 0, 32 + k);
            tick();
        end
        check_issue("drain_empty", 1'b0, 4'd0, 0, 0, 0);

        // Flush overrides dispatch, issue and wakeup
        issue_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(ALU_SUB, 50, 1'b0, 0, 2, 1'b1, 0, 40 + i);
            tick();
        end
        flush_i       = 1'b1;
        issue_ready_i = 1'b1;
        wb(1'b1, 50, 7);
        disp(ALU_ADD, 1, 1'b1, 1, 2, 1'b1, 1, 44);
        tick();
        flush_i = 1'b0;
        wb(1'b0, 0, 0);
        no_disp();
        settle();
        check_issue("flush", 1'b0, 4'd0, 0, 0, 0);
        check_eq("flush_ready", 64'(dispatch_ready_o), 64'd1);
        disp(ALU_XOR, 1, 1'b1, 32'hA, 2, 1'b1, 32'hB, 45);
        tick();
        no_disp();
        settle();
        check_issue("post_flush", 1'b1, ALU_XOR, 32'hA, 32'hB, 45);
        tick();
        check_issue("post_flush_empty", 1'b0, 4'd0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
